// File: rtl/avl_ram_slave.sv
// avl_ram_slave
// Avalon-MM style on-chip RAM responder. It services single-word reads and
// byte-enabled writes, inserts WAIT_STATES waitrequest cycles before it
// accepts each command, and returns read data through a READ_LATENCY-deep
// valid/data pipeline.
//
// Ports
//   clk                in   clock, rising edge
//   rest               in   asynchronous active-low reset
//   avl_address        in   byte address (word index = [log2(DEPTH)+1:2])
//   avl_byteenable     in   write byte lanes
//   avl_read           in   read request
//   avl_write          in   write request (wins over a simultaneous read)
//   avl_writedata      in   write data
//   avl_waitrequest    out  command not accepted this cycle
//   avl_readdata       out  read data, holds between responses
//   avl_readdatavalid  out  avl_readdata is valid this cycle
//
// The RAM has no initial contents.

module avl_ram_slave #(
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 4096,
   parameter int WAIT_STATES  = 0,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "ram.hex"
) (
   input  logic              clk,
   input  logic              rest,
   input  logic [ADDR_W-1:0] avl_address,
   input  logic [3:0]        avl_byteenable,
   input  logic              avl_read,
   input  logic              avl_write,
   input  logic [31:0]       avl_writedata,
   output logic              avl_waitrequest,
   output logic [31:0]       avl_readdata,
   output logic              avl_readdatavalid
);

   localparam int        IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WS   = 4'(WAIT_STATES);

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] idx;
   logic [31:0]      mem_rdata;
   logic             unused_addr;

   logic             cmd_present;
   logic             accept;
   logic             wr_accept;
   logic             rd_accept;

   logic [3:0]       wcnt_q, wcnt_d;

   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [31:0]             dat_q [READ_LATENCY];
   logic [31:0]             dat_d [READ_LATENCY];

   // Upper address bits alias the RAM, and bits [1:0] select nothing.
   assign idx         = avl_address[IDX_W+1:2];
   assign unused_addr = ^avl_address;

   assign cmd_present     = avl_read | avl_write;
   assign avl_waitrequest = !rest | (cmd_present & (wcnt_q != WS));
   assign accept          = cmd_present & !avl_waitrequest;
   assign wr_accept       = accept & avl_write;
   // A combined read+write is treated as a write with no read response.
   assign rd_accept       = accept & avl_read & !avl_write;

   // Wait counter restarts on every acceptance and whenever the master drops
   // the command, so each command sees the full wait-state count.
   always_comb begin
      wcnt_d = wcnt_q;
      if (!cmd_present || accept) begin
         wcnt_d = 4'd0;
      end else begin
         wcnt_d = wcnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         wcnt_q <= 4'd0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         for (int i = 0; i < 4; i++) begin
            if (avl_byteenable[i]) begin
               mem[idx][8*i +: 8] <= avl_writedata[8*i +: 8];
            end
         end
      end
   end

   // Asynchronous array read: a write landing on one edge is visible to a
   // read accepted on the following edge.
   assign mem_rdata = mem[idx];

   // Each data stage only loads when the stage feeding it holds a valid word,
   // so the final stage keeps the last response between reads.
   always_comb begin
      vld_d[0] = rd_accept;
      dat_d[0] = rd_accept ? mem_rdata : dat_q[0];
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         vld_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dat_q[i] <= 32'd0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   assign avl_readdatavalid = vld_q[READ_LATENCY-1];
   assign avl_readdata      = dat_q[READ_LATENCY-1];

   localparam int unused_init_w = $bits(INIT_FILE);

endmodule

// File: tb/tb_avl_ram_slave.sv
// Directed bench for avl_ram_slave. Four instances with different wait-state
// and latency settings run from a shared clock and reset; each scenario
// drives one instance and compares against hand-computed values.

module tb_avl_ram_slave;

   logic        clk;
   logic        rest;
   logic        rd   [4];
   logic        wr   [4];
   logic [31:0] addr [4];
   logic [3:0]  be   [4];
   logic [31:0] wdat [4];
   logic        wreq [4];
   logic [31:0] rdat [4];
   logic        rdv  [4];

   int n_chk;
   int n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   avl_ram_slave #(.ADDR_W(32), .DEPTH(16), .WAIT_STATES(0), .READ_LATENCY(1)) u_ram0 (
      .clk(clk), .rest(rest), .avl_address(addr[0]), .avl_byteenable(be[0]),
      .avl_read(rd[0]), .avl_write(wr[0]), .avl_writedata(wdat[0]),
      .avl_waitrequest(wreq[0]), .avl_readdata(rdat[0]), .avl_readdatavalid(rdv[0]));

   avl_ram_slave #(.ADDR_W(32), .DEPTH(64), .WAIT_STATES(3), .READ_LATENCY(2)) u_ram1 (
      .clk(clk), .rest(rest), .avl_address(addr[1]), .avl_byteenable(be[1]),
      .avl_read(rd[1]), .avl_write(wr[1]), .avl_writedata(wdat[1]),
      .avl_waitrequest(wreq[1]), .avl_readdata(rdat[1]), .avl_readdatavalid(rdv[1]));

   avl_ram_slave #(.ADDR_W(32), .DEPTH(64), .WAIT_STATES(0), .READ_LATENCY(3)) u_ram2 (
      .clk(clk), .rest(rest), .avl_address(addr[2]), .avl_byteenable(be[2]),
      .avl_read(rd[2]), .avl_write(wr[2]), .avl_writedata(wdat[2]),
      .avl_waitrequest(wreq[2]), .avl_readdata(rdat[2]), .avl_readdatavalid(rdv[2]));

   avl_ram_slave #(.ADDR_W(32), .DEPTH(4096), .WAIT_STATES(0), .READ_LATENCY(4)) u_ram3 (
      .clk(clk), .rest(rest), .avl_address(addr[3]), .avl_byteenable(be[3]),
      .avl_read(rd[3]), .avl_write(wr[3]), .avl_writedata(wdat[3]),
      .avl_waitrequest(wreq[3]), .avl_readdata(rdat[3]), .avl_readdatavalid(rdv[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Entered and left at posedge+1. Holds the command until accepted and
   // checks how many waitrequest cycles it saw.
   task automatic do_cmd(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input int ws_exp,
                         input string tag);
      int waits;
      waits   = 0;
      rd[k]   = r;
      wr[k]   = w;
      addr[k] = a;
      be[k]   = b;
      wdat[k] = d;
      #1;
      while (wreq[k] && waits < 20) begin
         @(posedge clk);
         #1;
         waits++;
      end
      chk({tag, "_waits"}, 32'(waits), 32'(ws_exp));
      @(posedge clk);
      #1;
      rd[k] = 1'b0;
      wr[k] = 1'b0;
   endtask

   task automatic rd_check(input int k, input logic [31:0] a, input int ws, input int rl,
                           input logic [31:0] exp, input string tag);
      int n;
      n = 1;
      do_cmd(k, 1'b1, 1'b0, a, 4'h0, 32'h0, ws, tag);
      while (!rdv[k] && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(rl));
      chk({tag, "_data"}, rdat[k], exp);
      @(posedge clk);
      #1;
      chk({tag, "_one_cycle"}, 32'(rdv[k]), 32'd0);
      chk({tag, "_hold"}, rdat[k], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          j;
      int          cnt;
      logic        v_s [11];
      logic [31:0] d_s [11];

      n_chk  = 0;
      n_pass = 0;
      rest   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; be[k] = 4'h0; wdat[k] = 32'h0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wreq0", 32'(wreq[0]), 32'd1);
      chk("rst_rdv0", 32'(rdv[0]), 32'd0);
      chk("rst_rdat0", rdat[0], 32'h0);
      chk("rst_rdat3", rdat[3], 32'h0);
      rest = 1'b1;
      #1;
      chk("idle_wreq0", 32'(wreq[0]), 32'd0);
      @(posedge clk);
      #1;

      // WS=0 RL=1: write then read on the very next edge
      do_cmd(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, "w10");
      rd_check(0, 32'h10, 0, 1, 32'hDEADBEEF, "r10");
      // Aliasing: 0x52 -> word (0x52>>2)%16 = 4, same as 0x10
      rd_check(0, 32'h52, 0, 1, 32'hDEADBEEF, "alias");

      // Byte enables: lanes 0 and 2 replaced
      do_cmd(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0, "w20");
      do_cmd(0, 1'b0, 1'b1, 32'h22, 4'h5, 32'hAABBCCDD, 0, "w22");
      rd_check(0, 32'h20, 0, 1, 32'h11BB33DD, "be");

      // Read+write together is a write with no response
      do_cmd(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'h00000005, 0, "rw30");
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (rdv[0]) cnt++;
         @(posedge clk);
         #1;
      end
      chk("rw_no_rdv", 32'(cnt), 32'd0);
      rd_check(0, 32'h30, 0, 1, 32'h00000005, "r30");

      // WS=3 RL=2
      do_cmd(1, 1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 3, "ws_w0");
      rd_check(1, 32'h0, 3, 2, 32'hCAFEF00D, "ws_r0");
      // Dropped command must leave no partial wait count behind
      rd[1] = 1'b1; addr[1] = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rd[1] = 1'b0;
      @(posedge clk); #1;
      do_cmd(1, 1'b0, 1'b1, 32'h4, 4'hF, 32'h12345678, 3, "ws_drop_w4");
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (rdv[1]) cnt++;
         @(posedge clk);
         #1;
      end
      chk("ws_drop_no_rdv", 32'(cnt), 32'd0);
      rd_check(1, 32'h4, 3, 2, 32'h12345678, "ws_r4");

      // WS=0 RL=3: four back-to-back reads
      for (int i = 0; i < 4; i++) begin
         do_cmd(2, 1'b0, 1'b1, 32'(i * 4), 4'hF, 32'hA0A00000 + 32'(i), 0, "p_w");
      end
      j = 0;
      for (int i = 0; i < 4; i++) begin
         rd[2] = 1'b1;
         addr[2] = 32'(i * 4);
         #1;
         chk("p_wreq", 32'(wreq[2]), 32'd0);
         @(posedge clk);
         #1;
         j++;
         v_s[j] = rdv[2];
         d_s[j] = rdat[2];
      end
      rd[2] = 1'b0;
      while (j < 10) begin
         @(posedge clk);
         #1;
         j++;
         v_s[j] = rdv[2];
         d_s[j] = rdat[2];
      end
      for (int m = 1; m <= 10; m++) begin
         chk($sformatf("p_vld%0d", m), 32'(v_s[m]), (m >= 3 && m <= 6) ? 32'd1 : 32'd0);
         if (m >= 3 && m <= 6) begin
            chk($sformatf("p_dat%0d", m), d_s[m], 32'hA0A00000 + 32'(m - 3));
         end
      end

      // RL=4: reset discards the in-flight read, RAM survives
      do_cmd(3, 1'b0, 1'b1, 32'h40, 4'hF, 32'h600DF00D, 0, "rl4_w");
      rd_check(3, 32'h40, 0, 4, 32'h600DF00D, "rl4_pre");
      rd[3] = 1'b1; addr[3] = 32'h40;
      @(posedge clk); #1;
      rd[3] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rest = 1'b0;
      #1;
      chk("rst_mid_rdv", 32'(rdv[3]), 32'd0);
      chk("rst_mid_rdat", rdat[3], 32'h0);
      chk("rst_mid_wreq", 32'(wreq[3]), 32'd1);
      @(posedge clk); #1;
      chk("rst_mid_rdat0", rdat[0], 32'h0);
      @(posedge clk); #1;
      rest = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (rdv[3]) cnt++;
         @(posedge clk);
         #1;
      end
      chk("rst_no_rdv", 32'(cnt), 32'd0);
      chk("rst_rdat_zero", rdat[3], 32'h0);
      rd_check(3, 32'h40, 0, 4, 32'h600DF00D, "rl4_post");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
